// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-port memory master.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        SETUP,
        PULSE,
        HOLD,
        RESP
    } state_e;

    // Memory map defaults: data region is 0 .. DATA_LIMIT_DEF-1, instructions above.
    localparam logic [31:0] MEM_SIZE_DEF   = 32'h0000_2000;
    localparam logic [31:0] DATA_LIMIT_DEF = 32'h0000_1000;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: load extract/extend and store merge.
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        is_signed,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane, extend it for loads, and splice new data in for stores.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        byte_v      = old_word[{off, 3'b000} +: 8];
        half_v      = old_word[{off[1], 4'b0000} +: 16];
        load_data   = old_word;
        merged_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{is_signed & byte_v[7]}}, byte_v};
                merged_word = old_word;
                merged_word[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{is_signed & half_v[15]}}, half_v};
                merged_word = old_word;
                merged_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data   = old_word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_master.sv
// Data-port initiator: load/store sequencing with read-modify-write for sub-word stores.
// Optional build macro STORE_PROTECT_EN makes stores at or above DATA_LIMIT an error.
module data_mem_master
    import data_mem_pkg::*;
#(
    parameter logic [31:0] MEM_SIZE   = MEM_SIZE_DEF,
    parameter logic [31:0] DATA_LIMIT = DATA_LIMIT_DEF,
    parameter int          READ_WAIT  = 2,
    parameter int          SETUP_CYC  = 1,
    parameter int          PULSE_CYC  = 2,
    parameter int          HOLD_CYC   = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

`ifdef STORE_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    localparam logic [3:0] RD_LOAD    = 4'(READ_WAIT - 1);
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYC - 1);

    state_e      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [1:0]  off_q;
    size_e       size_q;
    logic        signed_q;
    logic        we_q;

    size_e       req_sz;
    logic [32:0] end_addr;
    logic        misaligned;
    logic        out_of_range;
    logic        protect_hit;
    logic        req_err;
    logic        accept;
    logic        rd_last;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_sz       = size_e'(req_size);
    assign end_addr     = {1'b0, req_addr} + 33'(size_bytes(req_sz));
    assign misaligned   = ((req_sz == SZ_HALF) && req_addr[0]) ||
                          ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign out_of_range = end_addr > {1'b0, MEM_SIZE};
    assign protect_hit  = PROTECT && req_we && (req_addr >= DATA_LIMIT);
    assign req_err      = (req_sz == SZ_ILL) || misaligned || out_of_range || protect_hit;

    assign req_ready  = (state == IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign busy       = (state != IDLE);
    assign mem_read   = (state == RD);
    assign mem_write  = (state == PULSE);
    assign resp_valid = (state == RESP);
    assign rd_last    = (state == RD) && (cnt == 4'd0);

    mem_lane_align u_align (
        .off         (off_q),
        .size        (size_q),
        .is_signed   (signed_q),
        .old_word    (mem_rdata),
        .wdata       (mem_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State register and phase counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and counter reload; each timed phase ends when the counter hits zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_n = RESP;
                    end else if (!req_we || (req_sz != SZ_WORD)) begin
                        state_n = RD;
                        cnt_n   = RD_LOAD;
                    end else begin
                        state_n = SETUP;
                        cnt_n   = SETUP_LOAD;
                    end
                end
            end
            RD: begin
                if (cnt == 4'd0) begin
                    state_n = we_q ? SETUP : RESP;
                    cnt_n   = we_q ? SETUP_LOAD : 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_n = PULSE;
                    cnt_n   = PULSE_LOAD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LOAD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request capture, memory address/data registers and response payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            off_q      <= 2'b00;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            off_q      <= req_addr[1:0];
            size_q     <= req_sz;
            signed_q   <= req_signed;
            we_q       <= req_we;
            mem_addr   <= {req_addr[31:2], 2'b00};
            mem_wdata  <= req_wdata;
            resp_rdata <= 32'h0;
            resp_err   <= req_err;
        end else if (rd_last) begin
            // Loads latch the extended lane; sub-word stores latch the merged word to write back.
            if (we_q) begin
                mem_wdata <= merged_word;
            end else begin
                resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_master.sv
// Directed, table-driven bench for data_mem_master with a behavioural memory model.
// Build with STORE_PROTECT_EN defined to exercise the store-protection variant.
module tb_data_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    data_mem_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: level-sensitive read, byte writes spread over 4 clocks after mem_write rises.
    logic [7:0]  mem [0:8191];
    logic [12:0] ma;
    assign ma = {mem_addr[12:2], 2'b00};
    assign mem_rdata = mem_read ? {mem[ma + 13'd3], mem[ma + 13'd2], mem[ma + 13'd1], mem[ma]} : 32'h0;

    always @(posedge mem_write) begin
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            mem[{mem_addr[12:2], 2'b00} + 13'(i)] = mem_wdata[8*i +: 8];
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wd;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic [31:0] ewd,
                                input logic ee, input int lat, input int rd, input int wr);
        vec_t v;
        v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_wd = ewd; v.exp_err = ee;
        v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, follow it to resp_valid and compare timing, payload and memory traffic.
    task automatic run_vec(input int idx, input vec_t v);
        int lat, rd_cyc, wr_cyc, addr_bad, stab_bad, lo, hi;
        logic seen;
        logic [31:0] got_rdata;
        logic got_err;
        string tag;
        tag = $sformatf("v%0d", idx);
        lat = 0; rd_cyc = 0; wr_cyc = 0; addr_bad = 0; stab_bad = 0; seen = 1'b0;
        got_rdata = 32'h0; got_err = 1'b0;
        lo = (v.size == 2'b10) ? 1 : 3;
        hi = lo + 6;
        @(negedge clk);
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            if (mem_read) rd_cyc++;
            if (mem_write) wr_cyc++;
            if (mem_read && mem_write) overlap++;
            if (mem_read && mem_addr !== {v.addr[31:2], 2'b00}) addr_bad++;
            if (lat >= lo && lat <= hi &&
                (mem_addr !== {v.addr[31:2], 2'b00} || mem_wdata !== v.exp_wd)) stab_bad++;
            if (resp_valid) begin
                seen = 1'b1;
                got_rdata = resp_rdata;
                got_err = resp_err;
            end
        end
        check({tag, " resp seen"}, {31'b0, seen}, 32'd1);
        check({tag, " rdata"}, got_rdata, v.exp_rdata);
        check({tag, " err"}, {31'b0, got_err}, {31'b0, v.exp_err});
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " read cycles"}, rd_cyc, v.exp_rd);
        check({tag, " write cycles"}, wr_cyc, v.exp_wr);
        if (v.exp_rd > 0) check({tag, " read addr"}, addr_bad, 0);
        if (v.we && !v.exp_err) check({tag, " addr/data hold"}, stab_bad, 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[16'h10] = 8'h34; mem[16'h11] = 8'h12; mem[16'h12] = 8'hFF; mem[16'h13] = 8'h80;
        mem[16'h1FFF] = 8'hA5;

        // we size sgn addr wdata exp_rdata exp_wd err lat rd wr
        vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FF80, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 32'h0000_0080, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 32'h0000_80FF, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF_80FF, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h80FF_1234, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_0034, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h10, 32'h0, 32'h0000_1234, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h12, 32'h0000_ABCD, 32'h0, 32'hABCD_1234, 0, 10, 2, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hABCD_1234, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'hFFFF_FF5A, 32'h0, 32'hABCD_5A34, 0, 10, 2, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hABCD_5A34, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h20, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h2000, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h1FFF, 32'h0, 32'hFFFF_FFA5, 32'h0, 0, 3, 2, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h1FFE, 32'h1, 32'h0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0FFC, 32'h1122_3344, 32'h0, 32'h1122_3344, 0, 8, 0, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0FFC, 32'h0, 32'h1122_3344, 32'h0, 0, 3, 2, 0));
`ifdef STORE_PROTECT_EN
        vecs.push_back(mk(1, 2'b10, 0, 32'h1000, 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h1003, 32'h77, 32'h0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 32'h0, 0, 3, 2, 0));
`else
        vecs.push_back(mk(1, 2'b10, 0, 32'h1000, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 0, 8, 0, 2));
        vecs.push_back(mk(1, 2'b00, 0, 32'h1003, 32'h77, 32'h0, 32'h77AD_BEEF, 0, 10, 2, 2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h1000, 32'h0, 32'h77AD_BEEF, 32'h0, 0, 3, 2, 0));
`endif

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset ready", {31'b0, req_ready}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset mem ctl", {30'b0, mem_read, mem_write}, 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset asserted during the write pulse of a word store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h80; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort setup write", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        check("abort pulse write", {31'b0, mem_write}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort mem_write", {31'b0, mem_write}, 32'd0);
        check("abort resp_valid", {31'b0, resp_valid}, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort ready low", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort ready", {31'b0, req_ready}, 32'd1);
        check("abort no resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        run_vec(100, mk(1, 2'b10, 0, 32'h40, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 0, 8, 0, 2));
        run_vec(101, mk(0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFE_F00D, 32'h0, 0, 3, 2, 0));

        check("read/write overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- Initiator for the data port of the integrated instruction/data memory; sits between the pipeline load/store stage and the memory's data side.
- Accepts one load or store request at a time through a valid/ready handshake.
- Sequences the memory's level-sensitive read and posedge-triggered write with fixed setup, pulse and hold timing.
- Performs read-modify-write for byte and halfword stores, and extracts and extends load data.

Parameters:
- MEM_SIZE, 32'h0000_2000, total byte size of the memory; any access with addr+bytes > MEM_SIZE is an error.
- DATA_LIMIT, 32'h0000_1000, first byte of the instruction region (data region is 0x0000..DATA_LIMIT-1).
- READ_WAIT, 2, cycles mem_read is held before mem_rdata is sampled (range 1..15).
- SETUP_CYC, 1, cycles address and data are stable before mem_write rises (range 1..15).
- PULSE_CYC, 2, cycles mem_write is high (range 1..15).
- HOLD_CYC, 4, cycles address and data are held after mem_write falls; covers the memory's 4-step delayed byte writes (range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid
- busy  out  1  state != IDLE
- mem_addr  out  32  to memory data_addr; always word-aligned
- mem_wdata  out  32  to memory data_in
- mem_read  out  1  to memory mem_read
- mem_write  out  1  to memory mem_write
- mem_rdata  in  32  from memory data_out, little-endian

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: all registered outputs are 0 and state is IDLE. req_ready = (state==IDLE) && rst_n, so it reads 0 while rst_n is low.
- States: IDLE, RD, SETUP, PULSE, HOLD, RESP. A single 4-bit down-counter times RD, SETUP, PULSE and HOLD.
- Accept: req_valid && req_ready at edge T captures addr, size, signed, we and wdata. Inputs are ignored outside IDLE.
- Error check at accept. Error conditions:
  - size==11
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - out of range (see MEM_SIZE)
  - store protection violation (see Optional Feature)
  On error, go to RESP with resp_err=1. No mem_read or mem_write is ever asserted. resp_valid rises at T+1.
- Load: RD for READ_WAIT cycles with mem_read=1 and mem_addr=addr&~3. mem_rdata is sampled on the last RD edge.
  - Lane select uses addr[1:0]: byte lane = addr[1:0]; half lane = addr[1].
  - Result is zero- or sign-extended per req_signed.
  - With defaults, resp_valid occurs at T+3.
- Word store: SETUP (mem_write=0), then PULSE (mem_write=1), then HOLD (mem_write=0), then RESP.
  - mem_addr and mem_wdata are constant from the first SETUP cycle through the last HOLD cycle.
  - mem_write is exactly PULSE_CYC cycles wide; one rising edge per store.
  - With defaults, resp_valid occurs at T+8.
- Sub-word store: RD as for a load, then merge the new byte or half into the sampled word, then SETUP/PULSE/HOLD.
  - mem_read is 0 in SETUP, PULSE and HOLD.
  - With defaults, resp_valid occurs at T+10.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The earliest next accept is the RESP+1 edge; no zero-cycle back-to-back.
- mem_read and mem_write are never high in the same cycle.
- Reset mid-operation: the next edge returns to IDLE with mem_read=mem_write=0 and no resp_valid. A partially written memory word is not rolled back.

Optional Feature:
- Macro STORE_PROTECT_EN.
- Defined: a store with addr >= DATA_LIMIT is an error (resp_err=1, no memory cycle).
- Undefined: stores anywhere below MEM_SIZE are allowed, including the instruction region (self-modifying code permitted).
- Loads are never restricted by this feature.

Decomposition:
- Package data_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum
  - region constants matching the defaults
- One combinational sub-module, mem_lane_align:
  - load extract and extend: addr[1:0], size, signed, word -> result
  - store merge: addr[1:0], size, old word, wdata -> new word
- The FSM and counter stay in data_mem_master.

Test Plan:
- Preload bytes 0x10..0x13 = 34 12 FF 80. Signed byte load at 0x0013 -> resp_rdata=0xFFFFFF80 at T+3; mem_addr=0x0010; mem_read high 2 cycles.
- Unsigned half load at 0x0012 -> 0x000080FF. Signed half load at 0x0012 -> 0xFFFF80FF. Word load at 0x0010 -> 0x80FF1234.
- Half store 0xABCD to 0x0012 -> word 0x0010 reads 0xABCD1234. resp_valid at T+10; mem_write high exactly 2 cycles; mem_addr=0x0010 and mem_wdata=0xABCD1234 stable across SETUP..HOLD.
- Word load at 0x0011 and size=11 at 0x0020 -> resp_err=1 at T+1; mem_read and mem_write never asserted.
- Word store 0xDEADBEEF to 0x1000:
  - STORE_PROTECT_EN defined -> resp_err=1; memory unchanged.
  - STORE_PROTECT_EN undefined -> word 0x1000 reads 0xDEADBEEF.
- rst_n low for one cycle during PULSE -> mem_write=0 on the next edge; no resp_valid; req_ready=1 after release; a following word store to 0x0040 completes normally.
